// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive side of the UART. The asynchronous rx pin is synchronized and
//   oversampled. 8N1 frames (LSB first) are rebuilt from majority-voted
//   mid-bit samples, and good bytes are pushed into a show-ahead FIFO that
//   the CPU-facing register logic reads.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idles high
//   rd         pop strobe, ignored while the FIFO is empty
//   clr_err    clears the sticky overrun / frame_err flags
//   rx_data    FIFO head (0 when empty)
//   rx_valid   FIFO not empty
//   rx_count   number of stored entries
//   overrun    sticky: a good byte was dropped because the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
//
// Receiver states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line idle; armed once rxs has been seen high
//   S_START | checking the start bit mid-bit (rejects false starts)
//   S_DATA  | shifting in data bits 0..7
//   S_STOP  | checking the stop bit; good byte is written mid-stop-bit
//   S_BREAK | stop bit was low; wait for the line to return high

module uart_rx_fifo #(
  parameter int ClkFrequency = 25_000_000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8,
  parameter int Depth        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx,
  input  logic                    rd,
  input  logic                    clr_err,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  output logic [$clog2(Depth):0]  rx_count,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam int SampleRate = Baud * Oversampling;
  localparam int Div        = (ClkFrequency + SampleRate / 2) / SampleRate;
  localparam int DivW       = (Div > 1) ? $clog2(Div) : 1;
  localparam int IdxW       = $clog2(Oversampling);
  localparam int PtrW       = $clog2(Depth);
  localparam int CntW       = PtrW + 1;

  localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(Oversampling - 1);
  localparam logic [IdxW-1:0] IdxS0   = IdxW'(Oversampling / 2 - 1);
  localparam logic [IdxW-1:0] IdxS1   = IdxW'(Oversampling / 2);
  localparam logic [IdxW-1:0] IdxDec  = IdxW'(Oversampling / 2 + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  if (Div < 1) begin : g_div_check
    $error("uart_rx_fifo: clock too slow for Baud*Oversampling (Div < 1)");
  end
  if (Oversampling < 4 || Oversampling > 16 || (Oversampling % 2) != 0) begin : g_os_check
    $error("uart_rx_fifo: Oversampling must be even and within 4..16");
  end
  if (Depth < 2 || Depth > 16 || (Depth & (Depth - 1)) != 0) begin : g_depth_check
    $error("uart_rx_fifo: Depth must be a power of two within 2..16");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              rxs_q, rxs_d;
  logic [1:0]        flush_q, flush_d;
  logic              armed_q, armed_d;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        samp_q, samp_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        mem_q [Depth];
  logic [7:0]        mem_d [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic start_det;
  logic running;
  logic tick;
  logic dec_point;
  logic wrap;
  logic majority;
  logic push_req;
  logic ferr_set;
  logic full;
  logic pop;
  logic do_push;
  logic ovr_set;

  always_comb begin
    sync1_d = rx;
    rxs_d   = sync1_q;
    // Both synchronizer flops come out of reset at 1. Those reset ones are
    // not a real observation of the line, so arming waits until the
    // synchronizer has been refilled from the pin (two edges).
    flush_d = {flush_q[0], 1'b1};

    start_det = (state_q == S_IDLE) && armed_q && !rxs_q;
    running   = (state_q == S_START) || (state_q == S_DATA) ||
                (state_q == S_STOP) || start_det;
    tick      = running && (div_cnt_q == DivLast);
    dec_point = tick && (idx_q == IdxDec);
    wrap      = tick && (idx_q == IdxLast);
    majority  = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs_q) | (samp_q[0] & rxs_q);

    state_d  = state_q;
    armed_d  = 1'b0;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    ferr_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        armed_d = armed_q | (rxs_q & flush_q[1]);
        if (start_det) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (dec_point && majority) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (dec_point) begin
          shreg_d[bitcnt_q] = majority;
        end
        if (wrap) begin
          if (bitcnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        // Leave mid-stop-bit so a start bit that directly follows is seen.
        if (dec_point) begin
          if (majority) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
          armed_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE || state_d == S_BREAK) begin
      div_cnt_d = '0;
      idx_d     = '0;
    end else if (tick) begin
      div_cnt_d = '0;
      idx_d     = wrap ? '0 : idx_q + IdxW'(1);
    end else begin
      div_cnt_d = div_cnt_q + DivW'(1);
      idx_d     = idx_q;
    end

    samp_d = samp_q;
    if (tick && (idx_q == IdxS0 || idx_q == IdxS1)) begin
      samp_d = {samp_q[0], rxs_q};
    end

    // A pop on a full FIFO frees the slot the same-cycle write lands in;
    // pop is already gated by non-empty, so write+pop on empty is a write.
    full    = (count_q == CntFull);
    pop     = rd && (count_q != '0);
    do_push = push_req && (!full || pop);
    ovr_set = push_req && full && !pop;

    mem_d = mem_q;
    if (do_push) begin
      mem_d[wptr_q] = shreg_q;
    end
    wptr_d  = wptr_q + PtrW'(do_push);
    rptr_d  = rptr_q + PtrW'(pop);
    count_d = count_q + CntW'(do_push) - CntW'(pop);

    overrun_d   = ovr_set  ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    frame_err_d = ferr_set ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      flush_q     <= 2'b00;
      armed_q     <= 1'b0;
      div_cnt_q   <= '0;
      idx_q       <= '0;
      samp_q      <= 2'b00;
      bitcnt_q    <= 3'd0;
      shreg_q     <= 8'h00;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= 8'h00;
      end
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      samp_q      <= samp_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = (count_q != '0) ? mem_q[rptr_q] : 8'h00;
  assign rx_valid  = (count_q != '0);
  assign rx_count  = count_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo at 16 MHz / 1 Mbaud / 8x / depth 4 (16 clk per bit).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       overrun;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  localparam int Bit = 16;

  localparam int OP_FRAME = 0;
  localparam int OP_POP   = 1;
  localparam int OP_CLR   = 2;
  localparam int OP_LINE  = 3;

  typedef struct {
    int         op;
    logic [7:0] data;
    logic       level;
    int         nbits;
    logic       rd_hit;
    logic       clr_hit;
    int         cnt;
    logic [7:0] head;
    logic       ovr;
    logic       ferr;
  } vec_t;

  vec_t vecs[$];

  uart_rx_fifo #(
    .ClkFrequency(16_000_000),
    .Baud        (1_000_000),
    .Oversampling(8),
    .Depth       (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rd       (rd),
    .clr_err  (clr_err),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_count (rx_count),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #800_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int cnt, input logic [7:0] head,
                           input logic ovr, input logic ferr);
    check({tag, ".count"}, 32'(rx_count), 32'(cnt));
    check({tag, ".valid"}, 32'(rx_valid), 32'(cnt != 0));
    check({tag, ".data"},  32'(rx_data),  32'(head));
    check({tag, ".ovr"},   32'(overrun),  32'(ovr));
    check({tag, ".ferr"},  32'(frame_err), 32'(ferr));
  endtask

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  // rd/clr strobes land on the clock edge that applies the stop decision
  // (13 clk into the stop bit, given the 2-flop synchronizer).
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic rd_hit, input logic clr_hit);
    hold(1'b0, Bit);
    for (int i = 0; i < 8; i++) hold(d[i], Bit);
    hold(stop, 13);
    rd      = rd_hit;
    clr_err = clr_hit;
    hold(stop, 1);
    rd      = 1'b0;
    clr_err = 1'b0;
    hold(stop, 2);
  endtask

  task automatic pulse_pop();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  function automatic vec_t mk(input int op, input logic [7:0] data, input logic level,
                              input int nbits, input logic rd_hit, input logic clr_hit,
                              input int cnt, input logic [7:0] head, input logic ovr,
                              input logic ferr);
    vec_t v;
    v.op = op; v.data = data; v.level = level; v.nbits = nbits;
    v.rd_hit = rd_hit; v.clr_hit = clr_hit;
    v.cnt = cnt; v.head = head; v.ovr = ovr; v.ferr = ferr;
    return v;
  endfunction

  byte unsigned model_q[$];
  logic         model_ovr;

  initial begin
    //              op        data  lvl n  rd clr  cnt head  ovr ferr
    vecs.push_back(mk(OP_FRAME, 8'hA5, 1, 0, 0, 0,  1, 8'hA5, 0, 0));
    vecs.push_back(mk(OP_POP,   8'h00, 1, 0, 0, 0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_FRAME, 8'h5A, 1, 0, 1, 0,  1, 8'h5A, 0, 0));
    vecs.push_back(mk(OP_POP,   8'h00, 1, 0, 0, 0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_FRAME, 8'h01, 1, 0, 0, 0,  1, 8'h01, 0, 0));
    vecs.push_back(mk(OP_FRAME, 8'h02, 1, 0, 0, 0,  2, 8'h01, 0, 0));
    vecs.push_back(mk(OP_FRAME, 8'h03, 1, 0, 0, 0,  3, 8'h01, 0, 0));
    vecs.push_back(mk(OP_FRAME, 8'h04, 1, 0, 0, 0,  4, 8'h01, 0, 0));
    vecs.push_back(mk(OP_FRAME, 8'h05, 1, 0, 0, 0,  4, 8'h01, 1, 0));
    vecs.push_back(mk(OP_POP,   8'h00, 1, 0, 0, 0,  3, 8'h02, 1, 0));
    vecs.push_back(mk(OP_POP,   8'h00, 1, 0, 0, 0,  2, 8'h03, 1, 0));
    vecs.push_back(mk(OP_POP,   8'h00, 1, 0, 0, 0,  1, 8'h04, 1, 0));
    vecs.push_back(mk(OP_POP,   8'h00, 1, 0, 0, 0,  0, 8'h00, 1, 0));
    vecs.push_back(mk(OP_POP,   8'h00, 1, 0, 0, 0,  0, 8'h00, 1, 0));
    vecs.push_back(mk(OP_CLR,   8'h00, 1, 0, 0, 0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_FRAME, 8'h3C, 0, 0, 0, 1,  0, 8'h00, 0, 1));
    vecs.push_back(mk(OP_LINE,  8'h00, 0, 20, 0, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(OP_LINE,  8'h00, 1, 2, 0, 0,  0, 8'h00, 0, 1));
    vecs.push_back(mk(OP_FRAME, 8'h7E, 1, 0, 0, 0,  1, 8'h7E, 0, 1));
    vecs.push_back(mk(OP_CLR,   8'h00, 1, 0, 0, 0,  1, 8'h7E, 0, 0));
    vecs.push_back(mk(OP_POP,   8'h00, 1, 0, 0, 0,  0, 8'h00, 0, 0));

    rst = 1'b1; rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check_out("reset", 0, 8'h00, 0, 0);
    rst = 1'b0;
    hold(1'b1, 2 * Bit);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_FRAME: send_frame(vecs[i].data, vecs[i].level, vecs[i].rd_hit, vecs[i].clr_hit);
        OP_POP:   pulse_pop();
        OP_CLR:   pulse_clr();
        default:  hold(vecs[i].level, Bit * vecs[i].nbits);
      endcase
      check_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].head, vecs[i].ovr, vecs[i].ferr);
    end

    // short low pulse on an idle line is a false start
    hold(1'b0, 3);
    hold(1'b1, 3 * Bit);
    check_out("glitch_idle", 0, 8'h00, 0, 0);

    // one-clk high glitch on the centre sample of data bit 3 of 0x00
    hold(1'b0, Bit);
    hold(1'b0, 3 * Bit);
    hold(1'b0, 9);
    hold(1'b1, 1);
    hold(1'b0, 6);
    hold(1'b0, 4 * Bit);
    hold(1'b1, Bit);
    check_out("glitch_data", 1, 8'h00, 0, 0);
    pulse_pop();
    hold(1'b1, Bit);

    // full FIFO with a pop on the write edge of the 5th byte
    send_frame(8'h11, 1, 0, 0);
    send_frame(8'h22, 1, 0, 0);
    send_frame(8'h33, 1, 0, 0);
    send_frame(8'h44, 1, 0, 0);
    check_out("full4", 4, 8'h11, 0, 0);
    send_frame(8'h99, 1, 1, 0);
    check_out("full_pop", 4, 8'h22, 0, 0);
    pulse_pop(); check_out("drain1", 3, 8'h33, 0, 0);
    pulse_pop(); check_out("drain2", 2, 8'h44, 0, 0);
    pulse_pop(); check_out("drain3", 1, 8'h99, 0, 0);
    pulse_pop(); check_out("drain4", 0, 8'h00, 0, 0);

    // randomized traffic against a queue model
    model_q.delete();
    model_ovr = 1'b0;
    for (int k = 0; k < 30; k++) begin
      int          gap;
      int          npop;
      logic [7:0]  d;
      gap = $urandom_range(0, 3);
      if (gap != 0) hold(1'b1, Bit * gap);
      d = 8'($urandom);
      send_frame(d, 1, 0, 0);
      if (model_q.size() < 4) model_q.push_back(d);
      else model_ovr = 1'b1;
      check_out($sformatf("rnd%0d.rx", k), model_q.size(),
                (model_q.size() != 0) ? model_q[0] : 8'h00, model_ovr, 0);
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        pulse_pop();
        if (model_q.size() != 0) void'(model_q.pop_front());
        check_out($sformatf("rnd%0d.pop%0d", k, p), model_q.size(),
                  (model_q.size() != 0) ? model_q[0] : 8'h00, model_ovr, 0);
      end
    end

    // reset during data bit 2 of 0x00, line kept low afterwards
    hold(1'b1, Bit);
    send_frame(8'h12, 1, 0, 0);
    hold(1'b0, Bit);
    hold(1'b0, 2 * Bit);
    hold(1'b0, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_out("rst_mid", 0, 8'h00, 0, 0);
    hold(1'b0, 7 + 6 * Bit);
    check_out("rst_low", 0, 8'h00, 0, 0);
    hold(1'b1, 2 * Bit);
    send_frame(8'h55, 1, 0, 0);
    check_out("rst_after", 1, 8'h55, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receiver for the UART path: samples the asynchronous `rx` line at Oversampling× baud, reassembles 8N1 frames (LSB first), and pushes good bytes into a small show-ahead FIFO read by the CPU-facing bus logic. It is the receive-side counterpart of the UART transmitter. It sits between the external RX pin and the UART register device, which exposes `rx_data`, `rx_valid`, `rx_count` and the error flags on I/O reads.

## Interface
- `ClkFrequency`, 25_000_000: system clock in Hz.
- `Baud`, 115200: line rate in bit/s.
- `Oversampling`, 8: sample ticks per bit; legal values are 4..16 and must be even.
- `Depth`, 4: FIFO entries; must be a power of two, 2..16.
- Derived: `Div = round(ClkFrequency/(Baud*Oversampling))`. Elaboration must fail if `Div < 1`.

- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial line; idles high.
- `rd` input 1: pop strobe; one entry is popped per cycle it is high while `rx_valid` is high.
- `clr_err` input 1: clears `overrun` and `frame_err`.
- `rx_data` output 8: FIFO head (show-ahead); 0 when empty.
- `rx_valid` output 1: FIFO not empty.
- `rx_count` output log2(Depth)+1: current number of entries.
- `overrun` output 1: sticky; a good byte was dropped because the FIFO was full.
- `frame_err` output 1: sticky; a stop bit was sampled low.

## Operation
- **Synchronizer:** `rx` passes through 2 flops, both reset to 1. All logic uses the synchronized value `rxs`.
- **Tick generator:**
  - Counts 0..Div-1 and emits a 1-cycle `tick` on wrap.
  - Held at 0 in IDLE; starts counting on the cycle the start edge is detected.
- **Sample index:** counts 0..Oversampling-1 per bit, advancing on each tick.
- **Bit decision:** majority of 3 samples taken at indices Oversampling/2-1, Oversampling/2 and Oversampling/2+1. The decision is made on the tick at index Oversampling/2+1.
- **FSM:**
  - IDLE: armed only after `rxs` has been seen at 1. An armed 1→0 transition of `rxs` moves to START.
  - START: if the decision is 1 (false start), go to IDLE. If it is 0, go to DATA with the bit counter at 0 when the sample index wraps.
  - DATA: each decision shifts into bit[bitcnt] (LSB first). After bit 7 wraps, go to STOP.
  - STOP: if the decision is 1, the byte is good: request a FIFO write and go to IDLE immediately (mid-stop-bit, so the next start is not missed). If it is 0, set `frame_err`, discard the byte and go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE (armed).
- **FIFO:**
  - Uses `Depth` registers with wrap-around read and write pointers, plus a count.
  - Write when full (without a same-cycle pop): byte dropped, `overrun` set, contents unchanged.
  - Write and pop in the same cycle when full: both happen, count unchanged, no overrun.
  - Write and pop in the same cycle when empty: the write is accepted, the pop is ignored, count becomes 1.
  - `rd` while empty is ignored.
- **Error flags:** `clr_err` clears both flags. If a set event and `clr_err` occur in the same cycle, the set wins.
- **Reset:**
  - Outputs: `rx_valid`=0, `rx_count`=0, `rx_data`=0, `overrun`=0, `frame_err`=0.
  - FSM returns to IDLE disarmed; pointers, tick counter and shift register are cleared.
  - Reset mid-frame aborts the frame with no write. The receiver re-arms only after `rxs`=1, so trailing zero data bits are not taken as a start.

## Timing
- Synchronizer latency: 2 clk.
- Start detection: on the first cycle `rxs`=0 after being 1.
- Stop decision: made (Oversampling/2+1) ticks into the stop bit. The FIFO write occurs on the next edge, so `rx_valid`/`rx_count` update 1 clk after the decision.
- Pop: `rx_count` decrements and `rx_data` shows the next entry on the clk after `rd`.
- Tolerance: at Oversampling=8, baud mismatch up to ±3% must receive correctly.
- Back-to-back frames (stop bit directly followed by start bit) must be received without loss.

## Test plan
All scenarios use ClkFrequency=16_000_000, Baud=1_000_000, Oversampling=8, Depth=4 (Div=2, 16 clk/bit).
- **Single byte:** drive 8N1 0xA5 → `rx_valid`=1, `rx_data`=0xA5, `rx_count`=1, no flags. Pulse `rd` → `rx_valid`=0, `rx_data`=0.
- **Burst and overrun:** send 5 back-to-back bytes 0x01..0x05 with no reads → 0x01..0x04 stored, `overrun`=1 after the 5th frame. Popping 4 times yields 0x01, 0x02, 0x03, 0x04.
- **Framing error and break:** send 0x3C with the stop bit low, then hold the line low for 20 bits → `frame_err`=1, `rx_count`=0, no start is detected during the break. After the line goes high, 0x7E is received correctly. `clr_err` → flags return to 0.
- **Glitch rejection:** a low pulse of 3 clk on an idle line → no frame, `rx_count`=0. A single-clk high glitch in the middle of data bit 3 of 0x00 → byte reads 0x00.
- **Full with simultaneous pop:** fill to 4 entries, then assert `rd` on the write cycle of a 5th byte 0x99 → `rx_count` stays 4, `overrun`=0, and the last entry read out is 0x99.
- **Reset mid-frame:** assert `rst` for 1 clk during bit 2 of 0x00 (line low) → outputs return to reset values, no spurious start occurs while the line stays low, and a following 0x55 is received correctly after the line idles high.
